// File: rtl/mul4k_mod_unit_pkg.sv
// mul4k_mod_unit_pkg: shared field constants and FSM encoding for the a*4^k mod p unit
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef CHAR
`define CHAR 65521
`endif
`ifndef CHAR_2X
`define CHAR_2X 131042
`endif
`ifndef CHAR_3X
`define CHAR_3X 196563
`endif

package mul4k_mod_unit_pkg;
    localparam int WORD_W = `WORD_SIZE;
    // p, 2p and 3p widened to the signed difference width used by the x4 step
    localparam logic [WORD_W+2:0] P1 = (WORD_W+3)'(`CHAR);
    localparam logic [WORD_W+2:0] P2 = (WORD_W+3)'(`CHAR_2X);
    localparam logic [WORD_W+2:0] P3 = (WORD_W+3)'(`CHAR_3X);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mul4_mod_step.sv
// mul4_mod_step: combinational y = 4x mod p for x < p
module mul4_mod_step
    import mul4k_mod_unit_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);
    logic [WORD_W+2:0] x4;
    logic [WORD_W+2:0] d1;
    logic [WORD_W+2:0] d2;
    logic [WORD_W+2:0] d3;

    assign x4 = {1'b0, x, 2'b00};
    assign d1 = x4 - P1;
    assign d2 = x4 - P2;
    assign d3 = x4 - P3;

    // keep the difference with the largest multiple of p that stays non-negative
    always_comb begin
        y = !d3[WORD_W+2] ? d3[WORD_W-1:0] :
            !d2[WORD_W+2] ? d2[WORD_W-1:0] :
            !d1[WORD_W+2] ? d1[WORD_W-1:0] : x4[WORD_W-1:0];
    end
endmodule

// File: rtl/mul4k_mod_unit.sv
// mul4k_mod_unit: iterative c = a*4^k mod p, one x4 step per cycle
module mul4k_mod_unit
    import mul4k_mod_unit_pkg::*;
#(
    parameter int CNT_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [CNT_W-1:0]  k,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] c
);
    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] x_nxt;
    logic [WORD_W-1:0] y;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;

    mul4_mod_step u_step (
        .x(x),
        .y(y)
    );

    // start is only honoured outside RUN, so DONE can chain straight into a new job
    assign accept = start && (state != ST_RUN);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state: RUN counts down to DONE; IDLE/DONE launch on start
    always_comb begin
        state_nxt = (state == ST_RUN) ? ((cnt == CNT_W'(1)) ? ST_DONE : ST_RUN) :
                    accept            ? ((k != '0) ? ST_RUN : ST_DONE) : ST_IDLE;
    end

    // status outputs decoded from the current state
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // datapath next values: load on accept, step while running, hold otherwise
    always_comb begin
        x_nxt   = accept ? a : (state == ST_RUN) ? y : x;
        cnt_nxt = accept ? k : (state == ST_RUN) ? cnt - CNT_W'(1) : cnt;
    end

    // working registers; c captures the final x only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            cnt <= '0;
            c   <= '0;
        end else begin
            x   <= x_nxt;
            cnt <= cnt_nxt;
            if (state_nxt == ST_DONE) c <= x_nxt;
        end
    end
endmodule

// File: doc/mul4k_mod_unit.md
MUL4K_MOD_UNIT -- requirements
Module: mul4k_mod_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 9, giving the width of the iteration count k (k max 511).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port a, input, `WORD_SIZE, the operand; precondition a < p.
REQ-006 The block SHALL have port k, input, CNT_W, the number of x4 steps; sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high while in RUN.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse when c becomes valid.
REQ-009 The block SHALL have port c, output, `WORD_SIZE, the result a*4^k mod p; held until the next accepted start.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 IDLE + start SHALL capture x<=a and cnt<=k, then go to RUN if k!=0, else to DONE.
REQ-012 Each RUN cycle SHALL perform x <= 4x mod p and cnt <= cnt-1; when cnt==1 it SHALL go to DONE.
REQ-013 The x4 step SHALL form 4x (`WORD_SIZE+2 bits) and subtract p, 2p and 3p in parallel, each to `WORD_SIZE+3 bits with sign.
REQ-014 The x4 step SHALL select the largest multiple whose difference is non-negative, or 0 if none is, so the result is < p.
REQ-015 The DONE state SHALL assert done for exactly one cycle with c=x, then go to IDLE.
REQ-016 Latency SHALL be k+1 cycles from the start edge to done high; for k=0 it is 1 cycle.
REQ-017 A start while in DONE SHALL be accepted as in IDLE, allowing back-to-back operations.
REQ-018 A start while in RUN SHALL be ignored; a and k are not re-sampled.
REQ-019 c SHALL update only on entry to DONE; it SHALL be stable during RUN and IDLE.
REQ-020 If a >= p the result SHALL be unspecified; the block does no reduction of its input.

Reset
REQ-021 rst_n low SHALL force state=IDLE, x=0, cnt=0, c=0, busy=0 and done=0 immediately, including mid-operation.
REQ-022 After rst_n deasserts, the first start SHALL be accepted on the first rising edge it is sampled.

Structure
REQ-023 `WORD_SIZE, `CHAR, `CHAR_2X and `CHAR_3X SHALL come from the shared include/parameter.vh; `CHAR_2X SHALL be added there if absent.
REQ-024 The combinational 4x mod p step SHALL be one sub-module, mul4_mod_step (in x[`WORD_SIZE-1:0], out y[`WORD_SIZE-1:0]).
REQ-025 The FSM, counter and registers SHALL reside in mul4k_mod_unit.

Verification
REQ-026 Scenario 1: a=1, k=1 -> done at cycle 2, c=4.
REQ-027 Scenario 2: a=p-1, k=1 -> c=p-4; a=(p+1)/2, k=1 -> c=2.
REQ-028 Scenario 3: a=5, k=0 -> done 1 cycle after start, c=5.
REQ-029 Scenario 4: a=1, k=200 -> c equals the reference-model value of 2^400 mod p; done at cycle 201; start pulses at cycles 50 and 100 are ignored.
REQ-030 Scenario 5: start a=3, k=10; assert rst_n low at cycle 5 -> busy=0, done=0, c=0; restart a=3, k=2 -> c=48.
REQ-031 Scenario 6: 1000 random (a<p, k<=511) back-to-back jobs, each start issued in the done cycle -> every c matches the model and no cycle is lost.
